// File: rtl/logic_op_pipe_if.sv
// +----------------------------------------------------------------------+
// | Module : logic_op_pipe_if                                            |
// | Brief  : Stream bundle for logic_op_pipe. It carries the input beat   |
// |          handshake and the result handshake.                         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface logic_op_pipe_if #(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 16
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_s;
  logic [3:0]       op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bit;
  logic             out_log;
  logic [CNT_W-1:0] out_beats;
  logic             out_ovf;

  // Producer/consumer side: it drives the beats and the result ready
  modport master (
    output in_valid, in_a, in_b, in_s, op, in_last, out_ready,
    input  in_ready, out_valid, out_bit, out_log, out_beats, out_ovf
  );

  // Operator unit side
  modport slave (
    input  in_valid, in_a, in_b, in_s, op, in_last, out_ready,
    output in_ready, out_valid, out_bit, out_log, out_beats, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/logic_op_pipe.sv
// +----------------------------------------------------------------------+
// | Module : logic_op_pipe                                               |
// | Brief  : Registered bitwise/logical operator unit with valid/ready.   |
// |          It computes per-beat AND/OR/XOR/NAND and folds bursts with   |
// |          ACC_AND/ACC_OR.                                              |
// |          Optional macro LOGIC_OP_PIPE_STATS_EN adds port out_cnt      |
// |          (count of emitted results).                                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module logic_op_pipe #(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  logic_op_pipe_if.slave   bus
`ifdef LOGIC_OP_PIPE_STATS_EN
  ,
  output logic [15:0]      out_cnt
`endif
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_acc  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_acc_or;      // fold operator latched from the first beat
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_bit;
  logic             r_out_log;
  logic [CNT_W-1:0] r_out_beats;
  logic             r_out_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_bx;
  logic             w_in_acc;
  logic             w_is_acc;
  logic             w_fold_or;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_new_acc;
  logic [CNT_W-1:0] w_new_cnt;
  logic             w_cap;
  logic             w_emit;
  logic [WIDTH-1:0] w_res_bit;
  logic             w_res_log;
  logic [CNT_W-1:0] w_res_beats;
  logic             w_res_ovf;

  // The single output register frees up whenever it is empty or draining.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_bx       = bus.op[3] ? {WIDTH{bus.in_s}} : bus.in_b;

  // Once a burst is open, every beat folds with the latched operator.
  assign w_in_acc  = (r_state == c_st_acc);
  assign w_is_acc  = w_in_acc || (bus.op[2:1] == 2'b10);
  assign w_fold_or = w_in_acc ? r_acc_or : bus.op[0];
  assign w_term    = w_fold_or ? (bus.in_a | w_bx) : (bus.in_a & w_bx);
  assign w_new_acc = !w_in_acc ? w_term
                   : (r_acc_or ? (r_acc | w_term) : (r_acc & w_term));
  assign w_new_cnt = w_in_acc ? (r_cnt + c_one) : c_one;
  assign w_cap     = w_is_acc && !bus.in_last && (w_new_cnt == c_max);
  assign w_emit    = w_accept && (!w_is_acc || bus.in_last || w_cap);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // Next state: open a burst on a non-last ACC beat, close it on emission
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      if (r_state == c_st_idle) begin
        if (w_is_acc && !bus.in_last && !w_cap) w_state_nxt = c_st_acc;
      end else if (w_emit) begin
        w_state_nxt = c_st_idle;
      end
    end
  end

  // Result that would be loaded into the output register this cycle
  always_comb begin
    w_res_bit   = '0;
    w_res_log   = 1'b0;
    w_res_beats = c_one;
    w_res_ovf   = 1'b0;
    if (w_is_acc) begin
      w_res_bit   = w_new_acc;
      w_res_log   = |w_new_acc;
      w_res_beats = w_new_cnt;
      w_res_ovf   = w_cap;
    end else begin
      case (bus.op[2:0])
        3'b000: begin w_res_bit = bus.in_a & w_bx;    w_res_log = (|bus.in_a) &  (|w_bx);   end
        3'b001: begin w_res_bit = bus.in_a | w_bx;    w_res_log = (|bus.in_a) |  (|w_bx);   end
        3'b010: begin w_res_bit = bus.in_a ^ w_bx;    w_res_log = (|bus.in_a) ^  (|w_bx);   end
        3'b011: begin w_res_bit = ~(bus.in_a & w_bx); w_res_log = !((|bus.in_a) && (|w_bx)); end
        default: ;  // reserved ops emit zeros
      endcase
    end
  end

  // Burst accumulator and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_acc_or <= 1'b0;
    end else if (w_accept && w_is_acc) begin
      r_acc <= w_new_acc;
      r_cnt <= w_new_cnt;
      if (!w_in_acc) r_acc_or <= bus.op[0];
    end
  end

  // Output register: load on emission, otherwise hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_bit   <= '0;
      r_out_log   <= 1'b0;
      r_out_beats <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_bit   <= w_res_bit;
      r_out_log   <= w_res_log;
      r_out_beats <= w_res_beats;
      r_out_ovf   <= w_res_ovf;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef LOGIC_OP_PIPE_STATS_EN
  logic [15:0] r_out_cnt;

  // Count completed output transfers; wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_out_cnt <= '0;
    else if (r_out_valid && bus.out_ready) r_out_cnt <= r_out_cnt + 16'd1;
  end

  assign out_cnt = r_out_cnt;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bit   = r_out_bit;
  assign bus.out_log   = r_out_log;
  assign bus.out_beats = r_out_beats;
  assign bus.out_ovf   = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_logic_op_pipe.sv
// +----------------------------------------------------------------------+
// | Module : tb_logic_op_pipe                                            |
// | Brief  : Directed self-checking bench for logic_op_pipe (WIDTH=4,     |
// |          MAX_BEATS=4).                                                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_logic_op_pipe;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic_op_pipe_if #(.WIDTH(4), .MAX_BEATS(4)) bus ();

`ifdef LOGIC_OP_PIPE_STATS_EN
  logic [15:0] out_cnt;
  logic_op_pipe #(.WIDTH(4), .MAX_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .out_cnt(out_cnt));
`else
  logic_op_pipe #(.WIDTH(4), .MAX_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic s,
                      input logic [3:0] o, input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_s     = s;
    bus.op       = o;
    bus.in_last  = last;
    tick();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();
  endtask

  task automatic check_out(input string tag, input logic [3:0] b, input logic l,
                           input logic [2:0] n, input logic ov);
    check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, ".bit"},   {28'd0, bus.out_bit},   {28'd0, b});
    check({tag, ".log"},   {31'd0, bus.out_log},   {31'd0, l});
    check({tag, ".beats"}, {29'd0, bus.out_beats}, {29'd0, n});
    check({tag, ".ovf"},   {31'd0, bus.out_ovf},   {31'd0, ov});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_s      = 1'b0;
    bus.op        = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst.valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst.bit",   {28'd0, bus.out_bit},   32'd0);
    check("rst.log",   {31'd0, bus.out_log},   32'd0);
    check("rst.beats", {29'd0, bus.out_beats}, 32'd0);
    check("rst.ovf",   {31'd0, bus.out_ovf},   32'd0);
`ifdef LOGIC_OP_PIPE_STATS_EN
    check("rst.cnt", {16'd0, out_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Plain per-beat operators
    beat(4'b1101, 4'b1011, 1'b0, 4'd0, 1'b0);
    check_out("and", 4'b1001, 1'b1, 3'd1, 1'b0);
    idle();
    check("and.drain", {31'd0, bus.out_valid}, 32'd0);
`ifdef LOGIC_OP_PIPE_STATS_EN
    check("and.cnt", {16'd0, out_cnt}, 32'd1);
`endif
    beat(4'b1100, 4'b1010, 1'b0, 4'd2, 1'b0);
    check_out("xor", 4'b0110, 1'b0, 3'd1, 1'b0);
    beat(4'b0000, 4'b1111, 1'b0, 4'd3, 1'b0);
    check_out("nand", 4'b1111, 1'b1, 3'd1, 1'b0);
    beat(4'b0000, 4'b0000, 1'b0, 4'd1, 1'b0);
    check_out("or0", 4'b0000, 1'b0, 3'd1, 1'b0);
    beat(4'b1111, 4'b1111, 1'b0, 4'd6, 1'b0);
    check_out("rsvd", 4'b0000, 1'b0, 3'd1, 1'b0);

    // Scalar B replaces in_b entirely
    beat(4'b1101, 4'b1111, 1'b0, 4'b1000, 1'b0);
    check_out("scl0", 4'b0000, 1'b0, 3'd1, 1'b0);
    beat(4'b1101, 4'b0000, 1'b1, 4'b1000, 1'b0);
    check_out("scl1", 4'b1101, 1'b1, 3'd1, 1'b0);
    idle();

    // ACC_AND burst; later beats carry other ops which must be ignored
    beat(4'b1111, 4'b1111, 1'b0, 4'd4, 1'b0);
    check("acc.b1.valid", {31'd0, bus.out_valid}, 32'd0);
    check("acc.b1.ready", {31'd0, bus.in_ready},  32'd1);
    beat(4'b1101, 4'b1111, 1'b0, 4'd4, 1'b0);
    check("acc.b2.valid", {31'd0, bus.out_valid}, 32'd0);
    beat(4'b1001, 4'b1111, 1'b0, 4'd5, 1'b1);
    check_out("acc", 4'b1001, 1'b1, 3'd3, 1'b0);
    idle();

    // ACC_OR overflow at MAX_BEATS=4, beat 5 opens a new burst
    beat(4'b0001, 4'b0000, 1'b0, 4'd5, 1'b0);
    beat(4'b0010, 4'b0000, 1'b0, 4'd5, 1'b0);
    beat(4'b0000, 4'b0000, 1'b0, 4'd5, 1'b0);
    check("ovf.b3.valid", {31'd0, bus.out_valid}, 32'd0);
    beat(4'b0100, 4'b0000, 1'b0, 4'd5, 1'b0);
    check_out("ovf", 4'b0111, 1'b1, 3'd4, 1'b1);
    beat(4'b1000, 4'b0000, 1'b0, 4'd5, 1'b0);
    check("ovf.b5.valid", {31'd0, bus.out_valid}, 32'd0);
    beat(4'b0000, 4'b0000, 1'b0, 4'd5, 1'b1);
    check_out("ovf.next", 4'b1000, 1'b1, 3'd2, 1'b0);

    // One-beat scalar ACC_AND burst
    beat(4'b1010, 4'b0000, 1'b1, 4'b1100, 1'b1);
    check_out("acc1", 4'b1010, 1'b1, 3'd1, 1'b0);
    idle();

    // Backpressure: result A held two cycles, B waits, then full throughput
    bus.out_ready = 1'b0;
    beat(4'b1111, 4'b0011, 1'b0, 4'd0, 1'b0);
    check_out("bp.A", 4'b0011, 1'b1, 3'd1, 1'b0);
    bus.in_b = 4'b0101;
    #1;
    check("bp.ready0", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check_out("bp.hold1", 4'b0011, 1'b1, 3'd1, 1'b0);
    tick();
    check_out("bp.hold2", 4'b0011, 1'b1, 3'd1, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    check("bp.ready1", {31'd0, bus.in_ready}, 32'd1);
    tick();
    check_out("bp.B", 4'b0101, 1'b1, 3'd1, 1'b0);
    beat(4'b1111, 4'b1001, 1'b0, 4'd0, 1'b0);
    check_out("bp.C", 4'b1001, 1'b1, 3'd1, 1'b0);
    idle();
    check("bp.drain", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid ACC burst; out_bit still holds 4'b1001 from the last result
    beat(4'b0011, 4'b0000, 1'b0, 4'd5, 1'b0);
    beat(4'b0100, 4'b0000, 1'b0, 4'd5, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst.valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst.bit",   {28'd0, bus.out_bit},   32'd0);
    check("mrst.beats", {29'd0, bus.out_beats}, 32'd0);
`ifdef LOGIC_OP_PIPE_STATS_EN
    check("mrst.cnt", {16'd0, out_cnt}, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("mrst.none", {31'd0, bus.out_valid}, 32'd0);
    beat(4'b0010, 4'b0000, 1'b0, 4'd5, 1'b1);
    check_out("mrst.new", 4'b0010, 1'b1, 3'd1, 1'b0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
